// File: rtl/bus_demux2.sv
// One-outstanding request demultiplexer: steers the CPU data-memory channel to
// data RAM (target 0) or MMIO (target 1) by a single address bit.
module bus_demux2 #(
    parameter int N       = 32,
    parameter int AW      = 32,
    parameter int SEL_BIT = 31
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic          up_we,
    input  logic [AW-1:0] up_addr,
    input  logic [N-1:0]  up_wdata,
    output logic          up_rvalid,
    output logic [N-1:0]  up_rdata,
    output logic          up_wack,
    output logic          d0_valid,
    output logic          d1_valid,
    input  logic          d0_ready,
    input  logic          d1_ready,
    output logic          d0_we,
    output logic          d1_we,
    output logic [AW-1:0] d0_addr,
    output logic [AW-1:0] d1_addr,
    output logic [N-1:0]  d0_wdata,
    output logic [N-1:0]  d1_wdata,
    input  logic          d0_rvalid,
    input  logic          d1_rvalid,
    input  logic [N-1:0]  d0_rdata,
    input  logic [N-1:0]  d1_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t          state_r;
    logic            sel_r;
    logic            we_r;
    logic [AW-1:0]   addr_r;
    logic [N-1:0]    wdata_r;
    logic            rvalid_r;
    logic            wack_r;
    logic [N-1:0]    rdata_r;

    logic            dsel_ready_s;
    logic            dsel_rvalid_s;
    logic [N-1:0]    dsel_rdata_s;

    // Pick the handshake inputs of the captured target; the other side is ignored.
    always_comb begin
        dsel_ready_s  = 1'b0;
        dsel_rvalid_s = 1'b0;
        dsel_rdata_s  = '0;
        if (sel_r) begin
            dsel_ready_s  = d1_ready;
            dsel_rvalid_s = d1_rvalid;
            dsel_rdata_s  = d1_rdata;
        end else begin
            dsel_ready_s  = d0_ready;
            dsel_rvalid_s = d0_rvalid;
            dsel_rdata_s  = d0_rdata;
        end
    end

    // Transaction FSM with captured request and registered upstream responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            sel_r    <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rvalid_r <= 1'b0;
            wack_r   <= 1'b0;
            rdata_r  <= '0;
        end else begin
            rvalid_r <= 1'b0;
            wack_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (up_valid) begin
                        sel_r   <= up_addr[SEL_BIT];
                        we_r    <= up_we;
                        addr_r  <= up_addr;
                        wdata_r <= up_wdata;
                        state_r <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (dsel_ready_s) begin
                        if (we_r) begin
                            wack_r  <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            state_r <= WAIT_RD;
                        end
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                WAIT_RD: begin
                    if (dsel_rvalid_s) begin
                        rdata_r  <= dsel_rdata_s;
                        rvalid_r <= 1'b1;
                        state_r  <= IDLE;
                    end else begin
                        state_r <= WAIT_RD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode the state register only, so reset drops them at once.
    assign up_ready  = (state_r == IDLE);
    assign d0_valid  = (state_r == ISSUE) && !sel_r;
    assign d1_valid  = (state_r == ISSUE) && sel_r;

    assign d0_we     = we_r;
    assign d1_we     = we_r;
    assign d0_addr   = addr_r;
    assign d1_addr   = addr_r;
    assign d0_wdata  = wdata_r;
    assign d1_wdata  = wdata_r;

    assign up_rvalid = rvalid_r;
    assign up_wack   = wack_r;
    assign up_rdata  = rdata_r;

endmodule
